// File: rtl/hc_multi.sv
// Multi-channel hysteresis comparator with per-channel debounce, edge pulses
// and an optional sticky interrupt (enabled by defining HC_MULTI_IRQ_EN).
module hc_multi #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     th,
  input  logic [NCH*WIDTH-1:0] ts1,
  input  logic [NCH*WIDTH-1:0] ts2,
  output logic [NCH-1:0]       out,
  output logic [NCH-1:0]       rise,
  output logic [NCH-1:0]       fall,
  output logic                 irq,
  input  logic                 irq_clr
);

  localparam int EW = WIDTH + 2;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    UP_PEND = 2'd1,
    HIGH    = 2'd2,
    DN_PEND = 2'd3
  } state_t;

  // Two guard bits keep the difference of any two extremes, and -th, exact.
  function automatic logic signed [EW-1:0] sdiff(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [EW-1:0] ea;
    logic signed [EW-1:0] eb;
    ea = {{2{a[WIDTH-1]}}, a};
    eb = {{2{b[WIDTH-1]}}, b};
    return ea - eb;
  endfunction

  logic signed [EW-1:0] th_p0;
  logic signed [EW-1:0] nth_p0;

  assign th_p0  = {2'b00, th};
  assign nth_p0 = -th_p0;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic signed [EW-1:0] diff_p0;
    logic                 up_p0;
    logic                 dn_p0;
    state_t               state_p1;
    logic [CW-1:0]        cnt_p1;
    logic                 rise_p1;
    logic                 fall_p1;

    // Stage p0: combinational compare of the live samples
    assign diff_p0 = sdiff(ts1[ch*WIDTH +: WIDTH], ts2[ch*WIDTH +: WIDTH]);
    assign up_p0   = diff_p0 > th_p0;
    assign dn_p0   = diff_p0 < nth_p0;

    // Stage p1: registered hysteresis state, debounce count and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_p1 <= LOW;
        cnt_p1   <= '0;
        rise_p1  <= 1'b0;
        fall_p1  <= 1'b0;
      end else begin
        rise_p1 <= 1'b0;
        fall_p1 <= 1'b0;
        case (state_p1)
          LOW: begin
            if (en && up_p0) begin
              if (DEBOUNCE == 1) begin
                state_p1 <= HIGH;
                rise_p1  <= 1'b1;
              end else begin
                state_p1 <= UP_PEND;
                cnt_p1   <= CNT_ONE;
              end
            end
          end
          UP_PEND: begin
            if (en) begin
              if (up_p0 && cnt_p1 == CNT_LAST) begin
                state_p1 <= HIGH;
                cnt_p1   <= '0;
                rise_p1  <= 1'b1;
              end else if (up_p0) begin
                cnt_p1 <= cnt_p1 + CNT_ONE;
              end else begin
                state_p1 <= LOW;
                cnt_p1   <= '0;
              end
            end
          end
          HIGH: begin
            if (en && dn_p0) begin
              if (DEBOUNCE == 1) begin
                state_p1 <= LOW;
                fall_p1  <= 1'b1;
              end else begin
                state_p1 <= DN_PEND;
                cnt_p1   <= CNT_ONE;
              end
            end
          end
          DN_PEND: begin
            if (en) begin
              if (dn_p0 && cnt_p1 == CNT_LAST) begin
                state_p1 <= LOW;
                cnt_p1   <= '0;
                fall_p1  <= 1'b1;
              end else if (dn_p0) begin
                cnt_p1 <= cnt_p1 + CNT_ONE;
              end else begin
                state_p1 <= HIGH;
                cnt_p1   <= '0;
              end
            end
          end
          default: begin
            state_p1 <= LOW;
            cnt_p1   <= '0;
          end
        endcase
      end
    end

    assign out[ch]  = (state_p1 == HIGH) || (state_p1 == DN_PEND);
    assign rise[ch] = rise_p1;
    assign fall[ch] = fall_p1;
  end

`ifdef HC_MULTI_IRQ_EN
  logic irq_p2;

  // Stage p2: sticky interrupt, a new pulse outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_p2 <= 1'b0;
    end else if ((|rise) || (|fall)) begin
      irq_p2 <= 1'b1;
    end else if (irq_clr) begin
      irq_p2 <= 1'b0;
    end
  end

  assign irq = irq_p2;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_hc_multi.sv
// Directed bench for hc_multi (WIDTH=8, NCH=2, DEBOUNCE=3) with a
// run-length reference model feeding an expected-value queue.
module tb_hc_multi;
  localparam int W   = 8;
  localparam int N   = 2;
  localparam int DEB = 3;
`ifdef HC_MULTI_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b1;
  logic [W-1:0]   th = 8'd5;
  logic [N*W-1:0] ts1 = '0;
  logic [N*W-1:0] ts2 = '0;
  logic [N-1:0]   out;
  logic [N-1:0]   rise;
  logic [N-1:0]   fall;
  logic           irq;
  logic           irq_clr = 1'b0;

  hc_multi #(.WIDTH(W), .NCH(N), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .th(th), .ts1(ts1), .ts2(ts2),
    .out(out), .rise(rise), .fall(fall), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] o;
    logic [N-1:0] r;
    logic [N-1:0] f;
    logic         i;
  } exp_t;

  exp_t exp_q[$];
  int   npass = 0;
  int   ntotal = 0;

  // reference model: consecutive qualifying edges per channel
  int   run[N];
  bit   mo[N];
  bit   mr[N];
  bit   mf[N];
  bit   mirq;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    ntotal++;
    assert (got === want) npass++;
    else $error("FAIL %s: observed %b expected %b", tag, got, want);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      run[c] = 0; mo[c] = 0; mr[c] = 0; mf[c] = 0;
    end
    mirq = 0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      e.o[c] = mo[c]; e.r[c] = mr[c]; e.f[c] = mf[c];
    end
    e.i = mirq;
    return e;
  endfunction

  task automatic pop_compare(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".out"}, out, e.o);
    chk({tag, ".rise"}, rise, e.r);
    chk({tag, ".fall"}, fall, e.f);
    chk({tag, ".irq"}, {1'b0, irq}, {1'b0, e.i});
  endtask

  // drive one edge worth of samples; model predicts, DUT is compared after the edge
  task automatic step(input string tag, input int a0, input int b0, input int a1, input int b1);
    int a[N];
    int b[N];
    bit any_pulse;
    logic [W-1:0] s;
    a[0] = a0; b[0] = b0; a[1] = a1; b[1] = b1;
    for (int c = 0; c < N; c++) begin
      s = W'(a[c]); ts1[c*W +: W] = s;
      s = W'(b[c]); ts2[c*W +: W] = s;
    end
    any_pulse = 0;
    for (int c = 0; c < N; c++) any_pulse |= mr[c] | mf[c];
    if (IRQ_ON) begin
      if (any_pulse) mirq = 1;
      else if (irq_clr) mirq = 0;
    end
    for (int c = 0; c < N; c++) begin
      bit q;
      int d;
      mr[c] = 0; mf[c] = 0;
      if (en) begin
        d = a[c] - b[c];
        q = mo[c] ? (d < -int'(th)) : (d > int'(th));
        if (q) begin
          run[c]++;
          if (run[c] == DEB) begin
            mo[c] = !mo[c];
            run[c] = 0;
            if (mo[c]) mr[c] = 1; else mf[c] = 1;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_snapshot());
    pop_compare(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    ts1 = 16'hA55A; ts2 = 16'h5AA5;
    #2;
    chk("reset_async.out", out, 2'b00);
    do_reset("reset");
    step("rel0", 0, 0, 0, 0);
    step("rel1", 0, 0, 0, 0);
    chk("rel_out", out, 2'b00);

    // ch0 rise after the third edge
    step("up1", 10, 4, 0, 0);
    step("up2", 10, 4, 0, 0);
    chk("up2_out", out, 2'b00);
    step("up3", 10, 4, 0, 0);
    chk("up3_out", out, 2'b01);
    chk("up3_rise", rise, 2'b01);
    step("up4", 10, 4, 0, 0);
    chk("up4_rise", rise, 2'b00);
    chk("irq_after_rise", {1'b0, irq}, {1'b0, IRQ_ON});
    irq_clr = 1'b1;
    step("clr1", 10, 4, 0, 0);
    irq_clr = 1'b0;
    chk("irq_cleared", {1'b0, irq}, 2'b00);

    // ch0 fall
    for (int k = 0; k < 3; k++) step("dn", 4, 10, 0, 0);
    chk("dn_fall", fall, 2'b01);
    chk("dn_out", out, 2'b00);
    step("dn4", 0, 0, 0, 0);
    chk("dn4_fall", fall, 2'b00);
    irq_clr = 1'b1;
    step("clr2", 0, 0, 0, 0);
    irq_clr = 1'b0;

    // diff exactly +-th never qualifies
    for (int k = 0; k < 6; k++) step("eq_p5", 10, 5, 0, 0);
    chk("eq_p5_out", out, 2'b00);
    for (int k = 0; k < 3; k++) step("go_hi", 20, 0, 0, 0);
    for (int k = 0; k < 6; k++) step("eq_m5", 5, 10, 0, 0);
    chk("eq_m5_out", out, 2'b01);
    for (int k = 0; k < 3; k++) step("go_lo", 0, 20, 0, 0);

    // ch1 glitch rejection
    step("gl1", 0, 0, 20, 0);
    step("gl2", 0, 0, 20, 0);
    step("gl3", 0, 0, 0, 0);
    chk("glitch_out", out, 2'b00);
    for (int k = 0; k < 3; k++) step("ch1_up", 0, 0, 20, 0);
    chk("ch1_up_out", out, 2'b10);
    chk("ch1_up_rise", rise, 2'b10);

    // extremes: no wrap in the difference
    for (int k = 0; k < 3; k++) step("ovf_hi", 127, -128, 0, 0);
    chk("ovf_hi_out", out, 2'b11);
    for (int k = 0; k < 3; k++) step("ovf_lo", -128, 127, 0, 0);
    chk("ovf_lo_out", out, 2'b10);
    th = 8'd255;
    for (int k = 0; k < 5; k++) step("th255", 127, -128, 0, 0);
    chk("th255_out", out, 2'b10);
    th = 8'd5;

    // clear coinciding with a fresh fall[1]: set wins
    irq_clr = 1'b1;
    step("clr3", 0, 0, 0, 0);
    irq_clr = 1'b0;
    chk("irq_clr3", {1'b0, irq}, 2'b00);
    for (int k = 0; k < 3; k++) step("ch1_dn", 0, 0, 0, 20);
    chk("ch1_dn_fall", fall, 2'b10);
    irq_clr = 1'b1;
    step("set_wins", 0, 0, 0, 0);
    irq_clr = 1'b0;
    chk("irq_set_wins", {1'b0, irq}, {1'b0, IRQ_ON});

    // freeze with en low
    step("fz1", 20, 0, 0, 0);
    step("fz2", 20, 0, 0, 0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) step("fz_hold", 20, 0, 0, 0);
    chk("fz_hold_out", out, 2'b00);
    en = 1'b1;
    step("fz_go", 20, 0, 0, 0);
    chk("fz_go_out", out, 2'b01);
    chk("fz_go_rise", rise, 2'b01);

    // reset during a pending qualification
    for (int k = 0; k < 3; k++) step("pre_lo", 0, 20, 0, 0);
    step("rp1", 20, 0, 0, 0);
    step("rp2", 20, 0, 0, 0);
    do_reset("mid_reset");
    step("rq1", 20, 0, 0, 0);
    step("rq2", 20, 0, 0, 0);
    chk("rq2_out", out, 2'b00);
    step("rq3", 20, 0, 0, 0);
    chk("rq3_out", out, 2'b01);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
